// File: rtl/toaster_seq_ctrl_if.sv
// Control and status bundle between a toaster sequencer and whatever drives it.
interface toaster_seq_ctrl_if #(
    parameter int LEVEL_W = 3,
    parameter int CNT_W   = 8
);
    logic               start_i;
    logic               cancel_i;
    logic [LEVEL_W-1:0] level_i;
    logic [1:0]         state_o;
    logic               heater_on_o;
    logic               busy_o;
    logic               done_o;
    logic               reject_o;
    logic [CNT_W-1:0]   phase_cnt_o;

    modport master (
        output start_i, cancel_i, level_i,
        input  state_o, heater_on_o, busy_o, done_o, reject_o, phase_cnt_o
    );

    modport slave (
        input  start_i, cancel_i, level_i,
        output state_o, heater_on_o, busy_o, done_o, reject_o, phase_cnt_o
    );
endinterface

// File: rtl/toaster_seq_ctrl.sv
// Toaster sequencing controller: warm-up, level-scaled toast and cool-down
// phases, each timed by a down-counter that expires when it reads zero.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for start; counter parked at 0
// WARMUP    | heater on, pre-heat timer running
// TOAST     | heater on, timer = level * TOAST_UNIT clocks
// COOL_DOWN | heater off, cool timer running; done pulses on exit
module toaster_seq_ctrl #(
    parameter int LEVEL_W       = 3,
    parameter int WARMUP_CYCLES = 4,
    parameter int TOAST_UNIT    = 8,
    parameter int COOL_CYCLES   = 6,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    toaster_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WARMUP    = 2'b01,
        TOAST     = 2'b10,
        COOL_DOWN = 2'b11
    } state_type;

    localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_CYCLES - 1);

    state_type          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               done_q, done_d;
    logic               reject_q, reject_d;
    logic [CNT_W-1:0]   toast_load;
    logic               heater_on;
    logic               busy;

    // Product is taken at counter width; level_q is never 0 once latched.
    assign toast_load = CNT_W'(level_q) * CNT_W'(TOAST_UNIT) - CNT_W'(1);

    // State, phase counter, latched level and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            level_q  <= '0;
            done_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            done_q   <= done_d;
            reject_q <= reject_d;
        end
    end

    // Next-state and counter decisions; cancel beats phase expiry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        done_d   = 1'b0;
        reject_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.start_i) begin
                    if (bus.level_i != '0) begin
                        level_d = bus.level_i;
                        cnt_d   = WARM_LOAD;
                        state_d = WARMUP;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            WARMUP: begin
                if (bus.cancel_i) begin
                    state_d = COOL_DOWN;
                    cnt_d   = COOL_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = TOAST;
                    cnt_d   = toast_load;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            TOAST: begin
                if (bus.cancel_i || cnt_q == '0) begin
                    state_d = COOL_DOWN;
                    cnt_d   = COOL_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            COOL_DOWN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Status decode from the state register only, so outputs stay glitch-free.
    always_comb begin
        heater_on = (state_q == WARMUP) || (state_q == TOAST);
        busy      = (state_q != IDLE);
    end

    assign bus.state_o     = state_q;
    assign bus.heater_on_o = heater_on;
    assign bus.busy_o      = busy;
    assign bus.done_o      = done_q;
    assign bus.reject_o    = reject_q;
    assign bus.phase_cnt_o = cnt_q;

endmodule

// File: tb/tb_toaster_seq_ctrl.sv
// Directed bench for toaster_seq_ctrl with default parameters.
module tb_toaster_seq_ctrl;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    toaster_seq_ctrl_if #(.LEVEL_W(3), .CNT_W(8)) bus ();

    toaster_seq_ctrl #(
        .LEVEL_W(3), .WARMUP_CYCLES(4), .TOAST_UNIT(8), .COOL_CYCLES(6), .CNT_W(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at the sample right after the accepting edge (k = 0); stops at the done sample.
    task automatic run_measure(input bit noise, output int done_at, output int heat,
                               output int busy_n, output int toast_n, output int rej_n);
        done_at = -1; heat = 0; busy_n = 0; toast_n = 0; rej_n = 0;
        for (int k = 0; k < 200; k++) begin
            if (bus.heater_on_o) heat++;
            if (bus.busy_o) busy_n++;
            if (bus.state_o == 2'b10) toast_n++;
            if (bus.reject_o) rej_n++;
            if (bus.done_o) begin
                done_at = k;
                break;
            end
            if (noise && k < 20) begin
                bus.start_i = k[0];
                bus.level_i = k[2:0];
            end else if (noise) begin
                bus.start_i = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        int d, h, b, t, r;
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.cancel_i = 1'b0;
        bus.level_i = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", 32'(bus.state_o), 0);
        chk("rst_cnt", 32'(bus.phase_cnt_o), 0);
        chk("rst_heater", 32'(bus.heater_on_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_done", 32'(bus.done_o), 0);
        chk("rst_reject", 32'(bus.reject_o), 0);
        rst_n = 1'b1;
        tick();
        bus.cancel_i = 1'b1;
        tick();
        chk("idle_cancel_ignored", 32'(bus.state_o), 0);
        bus.cancel_i = 1'b0;

        // 1: level 2 full run
        bus.start_i = 1'b1; bus.level_i = 3'd2;
        tick();
        bus.start_i = 1'b0;
        chk("t1_warm_state", 32'(bus.state_o), 1);
        chk("t1_warm_cnt", 32'(bus.phase_cnt_o), 3);
        run_measure(1'b0, d, h, b, t, r);
        chk("t1_done_at", 32'(d), 26);
        chk("t1_heat", 32'(h), 20);
        chk("t1_busy", 32'(b), 26);
        chk("t1_toast", 32'(t), 16);
        chk("t1_done_state", 32'(bus.state_o), 0);
        tick();
        chk("t1_done_pulse", 32'(bus.done_o), 0);

        // 2: level 0 rejected, then level 7
        bus.start_i = 1'b1; bus.level_i = 3'd0;
        tick();
        chk("t2_reject", 32'(bus.reject_o), 1);
        chk("t2_rej_state", 32'(bus.state_o), 0);
        chk("t2_rej_busy", 32'(bus.busy_o), 0);
        bus.start_i = 1'b0;
        tick();
        chk("t2_reject_pulse", 32'(bus.reject_o), 0);
        bus.start_i = 1'b1; bus.level_i = 3'd7;
        tick();
        bus.start_i = 1'b0;
        chk("t2_reject_on_accept", 32'(bus.reject_o), 0);
        repeat (4) tick();
        chk("t2_toast_state", 32'(bus.state_o), 2);
        chk("t2_toast_load", 32'(bus.phase_cnt_o), 55);
        run_measure(1'b0, d, h, b, t, r);
        chk("t2_done_at", 32'(d + 4), 66);
        chk("t2_toast", 32'(t), 56);
        tick();

        // 3: cancel at 5th TOAST clock, cancel ignored in COOL_DOWN
        bus.start_i = 1'b1; bus.level_i = 3'd3;
        tick();
        bus.start_i = 1'b0;
        repeat (8) tick();
        chk("t3_toast_state", 32'(bus.state_o), 2);
        chk("t3_toast_cnt", 32'(bus.phase_cnt_o), 19);
        bus.cancel_i = 1'b1;
        tick();
        chk("t3_cancel_state", 32'(bus.state_o), 3);
        chk("t3_cancel_cnt", 32'(bus.phase_cnt_o), 5);
        chk("t3_cancel_heater", 32'(bus.heater_on_o), 0);
        tick();
        chk("t3_cool_cancel_state", 32'(bus.state_o), 3);
        chk("t3_cool_cancel_cnt", 32'(bus.phase_cnt_o), 4);
        bus.cancel_i = 1'b0;
        repeat (4) tick();
        chk("t3_cool_cnt0", 32'(bus.phase_cnt_o), 0);
        chk("t3_no_early_done", 32'(bus.done_o), 0);
        tick();
        chk("t3_done", 32'(bus.done_o), 1);
        chk("t3_idle", 32'(bus.state_o), 0);
        chk("t3_idle_cnt", 32'(bus.phase_cnt_o), 0);
        tick();

        // 4a: cancel coincident with WARMUP expiry
        bus.start_i = 1'b1; bus.level_i = 3'd2;
        tick();
        bus.start_i = 1'b0;
        repeat (3) tick();
        chk("t4_warm_cnt0", 32'(bus.phase_cnt_o), 0);
        bus.cancel_i = 1'b1;
        tick();
        bus.cancel_i = 1'b0;
        chk("t4_cancel_wins", 32'(bus.state_o), 3);
        chk("t4_cancel_cnt", 32'(bus.phase_cnt_o), 5);
        run_measure(1'b0, d, h, b, t, r);
        chk("t4_cool_done", 32'(d), 6);
        tick();

        // 4b: start pulses and level changes mid-run ignored
        bus.start_i = 1'b1; bus.level_i = 3'd2;
        tick();
        run_measure(1'b1, d, h, b, t, r);
        bus.start_i = 1'b0;
        chk("t4_noise_done_at", 32'(d), 26);
        chk("t4_noise_toast", 32'(t), 16);
        chk("t4_noise_reject", 32'(r), 0);
        tick();
        chk("t4_no_restart", 32'(bus.state_o), 0);

        // 5: asynchronous reset mid-TOAST
        bus.start_i = 1'b1; bus.level_i = 3'd3;
        tick();
        bus.start_i = 1'b0;
        repeat (6) tick();
        chk("t5_pre_state", 32'(bus.state_o), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_state", 32'(bus.state_o), 0);
        chk("t5_async_heater", 32'(bus.heater_on_o), 0);
        chk("t5_async_busy", 32'(bus.busy_o), 0);
        chk("t5_async_cnt", 32'(bus.phase_cnt_o), 0);
        chk("t5_async_done", 32'(bus.done_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t5_post_done", 32'(bus.done_o), 0);
        chk("t5_post_state", 32'(bus.state_o), 0);
        bus.start_i = 1'b1; bus.level_i = 3'd1;
        tick();
        bus.start_i = 1'b0;
        run_measure(1'b0, d, h, b, t, r);
        chk("t5_rerun_done_at", 32'(d), 18);
        chk("t5_rerun_toast", 32'(t), 8);
        tick();

        // 6: start held high, back-to-back level-1 runs
        bus.start_i = 1'b1; bus.level_i = 3'd1;
        tick();
        run_measure(1'b0, d, h, b, t, r);
        chk("t6_run1_done_at", 32'(d), 18);
        chk("t6_run1_idle", 32'(bus.state_o), 0);
        tick();
        chk("t6_restart_state", 32'(bus.state_o), 1);
        chk("t6_restart_cnt", 32'(bus.phase_cnt_o), 3);
        chk("t6_restart_done_low", 32'(bus.done_o), 0);
        run_measure(1'b0, d, h, b, t, r);
        chk("t6_run2_done_at", 32'(d), 18);
        chk("t6_run2_idle", 32'(bus.state_o), 0);
        bus.start_i = 1'b0;
        tick();
        chk("t6_stop_state", 32'(bus.state_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/toaster_seq_ctrl.md
Name: toaster_seq_ctrl

Overview:
Parametrised toaster sequencing controller: a 4-state FSM (IDLE, WARMUP, TOAST, COOL_DOWN) with programmable phase durations and a per-run toast level.
- Adds start/cancel control, level latching, a done pulse, rejection of bad requests and a visible phase counter.
- Sits under the top-level wrapper; testbenches decode state_o into the state_type enum.

Parameters:
LEVEL_W, 3, width of toast level input.
WARMUP_CYCLES, 4, WARMUP phase length in clocks; must be >= 1.
TOAST_UNIT, 8, TOAST clocks per level step; must be >= 1.
COOL_CYCLES, 6, COOL_DOWN phase length in clocks; must be >= 1.
CNT_W, 8, phase counter width; must hold max(WARMUP_CYCLES, COOL_CYCLES, (2^LEVEL_W-1)*TOAST_UNIT)-1.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start_i  in  1  request a toast run; sampled in IDLE only.
cancel_i  in  1  abort heating; sampled in WARMUP/TOAST only.
level_i  in  LEVEL_W  toast level; sampled with an accepted start.
state_o  out  2  00 IDLE, 01 WARMUP, 10 TOAST, 11 COOL_DOWN.
heater_on_o  out  1  high in WARMUP and TOAST.
busy_o  out  1  high in any state other than IDLE.
done_o  out  1  one-cycle pulse when COOL_DOWN completes.
reject_o  out  1  one-cycle pulse when a start arrives with level_i == 0.
phase_cnt_o  out  CNT_W  clocks remaining in current phase, minus one.

Behaviour:
- All outputs are registered, with no combinational input-to-output path.
- Reset (rst_n low, asynchronous): state IDLE, counter 0, latched level 0; heater_on_o, busy_o, done_o, reject_o all 0.
- Reset mid-run returns to IDLE immediately, with no done pulse.
- IDLE:
  - start_i=1 and level_i!=0: latch level, load counter WARMUP_CYCLES-1, go to WARMUP on the next edge.
  - start_i=1 and level_i==0: stay IDLE, pulse reject_o for one cycle.
  - cancel_i is ignored.
- WARMUP:
  - Counter decrements each clock.
  - At counter==0: go to TOAST, load level_q*TOAST_UNIT-1. The product is computed at CNT_W bits.
- TOAST: at counter==0, go to COOL_DOWN and load COOL_CYCLES-1.
- COOL_DOWN:
  - At counter==0: go to IDLE and assert done_o in the same cycle IDLE first appears.
  - cancel_i is ignored.
- cancel_i in WARMUP or TOAST: go to COOL_DOWN on the next edge and load COOL_CYCLES-1. Cancel has priority over phase expiry in the same cycle.
- start_i while busy is ignored, and no reject is raised. level_i changes after acceptance have no effect.
- Latency: done_o asserts exactly WARMUP_CYCLES + level*TOAST_UNIT + COOL_CYCLES clocks after the edge that accepted start.
- A new start can be accepted in the cycle done_o is high, since state is IDLE.
- phase_cnt_o holds 0 in IDLE. Counter never wraps; expiry is detected at 0 before decrement.

Test Plan:
1. Defaults, level_i=2 start at edge 0 -> WARMUP for 4 clks, TOAST for 16, COOL_DOWN for 6; done_o high at edge 26 for 1 clk; heater_on_o high for 20 clks; busy_o high for 26.
2. start with level_i=0 -> reject_o one-cycle pulse, state stays 00, busy_o=0; level_i=7 start -> TOAST lasts 56 clks, done at edge 66.
3. level_i=3 run, cancel_i at 5th TOAST clk -> COOL_DOWN next edge, phase_cnt_o=5, done_o 6 clks later; cancel during COOL_DOWN has no effect.
4. cancel_i in the same cycle WARMUP counter hits 0 -> COOL_DOWN (not TOAST); start_i pulses during TOAST ignored; level_i toggled mid-run gives unchanged TOAST length.
5. rst_n low mid-TOAST -> outputs go to reset values without waiting for a clock edge; no done_o; after release, a new start runs normally.
6. start_i held high continuously, level 1 -> back-to-back runs, each done_o spaced 18 clks apart, state IDLE for exactly one cycle between runs.
